// File: rtl/opcode_pkg.sv
// Shared encodings for the 3-bit opcode machine: opcodes, combo selectors,
// FSM states and the instruction-pointer width helper.
package opcode_pkg;

    localparam logic [2:0] OP_ADV = 3'd0;
    localparam logic [2:0] OP_BXL = 3'd1;
    localparam logic [2:0] OP_BST = 3'd2;
    localparam logic [2:0] OP_JNZ = 3'd3;
    localparam logic [2:0] OP_BXC = 3'd4;
    localparam logic [2:0] OP_OUT = 3'd5;
    localparam logic [2:0] OP_BDV = 3'd6;
    localparam logic [2:0] OP_CDV = 3'd7;

    localparam logic [2:0] CMB_A   = 3'd4;
    localparam logic [2:0] CMB_B   = 3'd5;
    localparam logic [2:0] CMB_C   = 3'd6;
    localparam logic [2:0] CMB_RSV = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    // One extra bit so that stepping past the end of the store is still representable.
    function automatic int ip_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/opcode_core_out_fifo.sv
// Small output FIFO with push/pop/flush; head value reads as zero when empty.
module out_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == CW'(0));
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign rdata     = empty ? WIDTH'(0) : r_mem[r_rd_ptr];

    // Pointer and occupancy tracking; flush wins over any same-cycle pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_count  <= CW'(0);
        end else if (flush) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_count  <= CW'(0);
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/opcode_core.sv
// 3-bit-opcode execute machine: program store, fetch/decode/execute of eight
// opcodes on A/B/C, buffered output stream and a step-limit watchdog.
module opcode_core
    import opcode_pkg::*;
#(
    parameter int REG_W      = 48,
    parameter int PROG_DEPTH = 16,
    parameter int OUT_DEPTH  = 4,
    parameter int MAX_STEPS  = 65535
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          prog_we,
    input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
    input  logic [2:0]                    prog_wdata,
    input  logic [$clog2(PROG_DEPTH):0]   prog_len,
    input  logic [REG_W-1:0]              init_a,
    input  logic [REG_W-1:0]              init_b,
    input  logic [REG_W-1:0]              init_c,
    input  logic                          start,
    output logic                          busy,
    output logic                          halted,
    output logic                          aborted,
    output logic [2:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [REG_W-1:0]              reg_a,
    output logic [REG_W-1:0]              reg_b,
    output logic [REG_W-1:0]              reg_c
);

    localparam int PA_W = $clog2(PROG_DEPTH);
    localparam int IP_W = ip_width(PROG_DEPTH);
    localparam int SC_W = $clog2(MAX_STEPS + 1);

    logic [2:0]       r_mem [PROG_DEPTH];
    state_t           r_state, w_state_nxt;
    logic [IP_W-1:0]  r_ip, w_ip_nxt, r_len, w_len_nxt;
    logic [REG_W-1:0] r_a, r_b, r_c, w_a_nxt, w_b_nxt, w_c_nxt;
    logic [SC_W-1:0]  r_steps, w_steps_nxt;

    logic [IP_W-1:0]  w_ip1, w_ip2, w_lit_ip;
    logic [2:0]       w_opcode, w_operand;
    logic [REG_W-1:0] w_lit, w_combo, w_shift;
    logic             w_halt_chk, w_stall, w_exec, w_push, w_pop, w_start, w_last;
    logic             w_full, w_empty;

    assign w_ip1      = r_ip + IP_W'(1);
    assign w_ip2      = r_ip + IP_W'(2);
    assign w_opcode   = r_mem[r_ip[PA_W-1:0]];
    assign w_operand  = r_mem[w_ip1[PA_W-1:0]];
    assign w_lit      = REG_W'(w_operand);
    assign w_lit_ip   = IP_W'(w_operand);
    assign w_halt_chk = (w_ip1 >= r_len);
    // Compare the full combo value so large register operands cannot alias to small shifts.
    assign w_shift    = (w_combo >= REG_W'(REG_W)) ? REG_W'(0) : (r_a >> w_combo);

    assign w_pop   = !w_empty && out_ready;
    assign w_stall = (w_opcode == OP_OUT) && w_full && !w_pop;
    assign w_exec  = (r_state == ST_RUN) && !w_halt_chk && !w_stall;
    assign w_push  = w_exec && (w_opcode == OP_OUT);
    assign w_start = start && (r_state != ST_RUN);
    assign w_last  = (r_steps == SC_W'(MAX_STEPS - 1));

    assign busy      = (r_state == ST_RUN);
    assign halted    = (r_state == ST_HALT);
    assign aborted   = (r_state == ST_ABORT);
    assign out_valid = !w_empty;
    assign reg_a     = r_a;
    assign reg_b     = r_b;
    assign reg_c     = r_c;

    // Combo operand decode.
    always_comb begin
        w_combo = REG_W'(0);
        case (w_operand)
            CMB_A:   w_combo = r_a;
            CMB_B:   w_combo = r_b;
            CMB_C:   w_combo = r_c;
            CMB_RSV: w_combo = REG_W'(0);
            default: w_combo = w_lit;
        endcase
    end

    // Next-state logic for the run FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_HALT, ST_ABORT: begin
                if (w_start) w_state_nxt = ST_RUN;
                else         w_state_nxt = r_state;
            end
            ST_RUN: begin
                if (w_halt_chk)           w_state_nxt = ST_HALT;
                else if (w_exec && w_last) w_state_nxt = ST_ABORT;
                else                      w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath next values: load on start, otherwise execute one instruction.
    always_comb begin
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_c_nxt     = r_c;
        w_ip_nxt    = r_ip;
        w_len_nxt   = r_len;
        w_steps_nxt = r_steps;
        if (w_start) begin
            w_a_nxt     = init_a;
            w_b_nxt     = init_b;
            w_c_nxt     = init_c;
            w_ip_nxt    = IP_W'(0);
            w_len_nxt   = prog_len;
            w_steps_nxt = SC_W'(0);
        end else if (w_exec) begin
            w_steps_nxt = r_steps + SC_W'(1);
            w_ip_nxt    = w_ip2;
            case (w_opcode)
                OP_ADV:  w_a_nxt  = w_shift;
                OP_BXL:  w_b_nxt  = r_b ^ w_lit;
                OP_BST:  w_b_nxt  = REG_W'(w_combo[2:0]);
                OP_JNZ:  w_ip_nxt = (r_a != REG_W'(0)) ? w_lit_ip : w_ip2;
                OP_BXC:  w_b_nxt  = r_b ^ r_c;
                OP_OUT:  w_a_nxt  = r_a;
                OP_BDV:  w_b_nxt  = w_shift;
                OP_CDV:  w_c_nxt  = w_shift;
                default: w_a_nxt  = r_a;
            endcase
        end else begin
            w_ip_nxt = r_ip;
        end
    end

    // Architectural state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_ip    <= IP_W'(0);
            r_len   <= IP_W'(0);
            r_a     <= REG_W'(0);
            r_b     <= REG_W'(0);
            r_c     <= REG_W'(0);
            r_steps <= SC_W'(0);
        end else begin
            r_state <= w_state_nxt;
            r_ip    <= w_ip_nxt;
            r_len   <= w_len_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_c     <= w_c_nxt;
            r_steps <= w_steps_nxt;
        end
    end

    // Program store is deliberately left unreset; writes are locked out during a run.
    always_ff @(posedge clk) begin
        if (prog_we && (r_state != ST_RUN)) r_mem[prog_addr] <= prog_wdata;
    end

    out_fifo #(
        .WIDTH (3),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_start),
        .wdata (w_combo[2:0]),
        .rdata (out_data),
        .full  (w_full),
        .empty (w_empty)
    );

endmodule

// File: tb/tb_opcode_core.sv
// Directed, table-driven bench for opcode_core, with hand-written sequences
// for backpressure, mid-run reset, program lockout and the step limit.
module tb_opcode_core;

    logic        clk, rstn, prog_we, start, out_ready;
    logic [3:0]  prog_addr;
    logic [2:0]  prog_wdata;
    logic [4:0]  prog_len;
    logic [47:0] init_a, init_b, init_c;

    logic        busy, halted, aborted, out_valid;
    logic [2:0]  out_data;
    logic [47:0] reg_a, reg_b, reg_c;

    logic        busy_s, halted_s, aborted_s, out_valid_s;
    logic [2:0]  out_data_s;
    logic [47:0] reg_a_s, reg_b_s, reg_c_s;

    int n_pass  = 0;
    int n_total = 0;
    logic [2:0] got_q[$];

    opcode_core dut (
        .clk(clk), .rstn(rstn), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .prog_len(prog_len), .init_a(init_a),
        .init_b(init_b), .init_c(init_c), .start(start), .busy(busy),
        .halted(halted), .aborted(aborted), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .reg_a(reg_a),
        .reg_b(reg_b), .reg_c(reg_c)
    );

    opcode_core #(.MAX_STEPS(10)) dut_s (
        .clk(clk), .rstn(rstn), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .prog_len(prog_len), .init_a(init_a),
        .init_b(init_b), .init_c(init_c), .start(start), .busy(busy_s),
        .halted(halted_s), .aborted(aborted_s), .out_data(out_data_s),
        .out_valid(out_valid_s), .out_ready(out_ready), .reg_a(reg_a_s),
        .reg_b(reg_b_s), .reg_c(reg_c_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program and expected outputs are nibble-packed, word 0 in the top nibble.
    typedef struct packed {
        logic [63:0] prog;
        logic [4:0]  len;
        logic [47:0] ia, ib, ic;
        logic [47:0] ea, eb, ec;
        logic [7:0]  nout;
        logic [39:0] eout;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic load_prog(input logic [63:0] prog);
        for (int i = 0; i < 16; i++) begin
            prog_we    = 1'b1;
            prog_addr  = 4'(i);
            prog_wdata = prog[60-4*i +: 3];
            tick();
        end
        prog_we = 1'b0;
    endtask

    task automatic kick(input logic [4:0] len, input logic [47:0] a, b, c);
        prog_len = len;
        init_a   = a;
        init_b   = b;
        init_c   = c;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Runs until the machine stops and the stream drains, collecting every pop.
    task automatic collect(input bit we_mid, input string name);
        int cyc;
        cyc = 0;
        got_q.delete();
        while ((busy || out_valid) && cyc < 500) begin
            if (we_mid && cyc == 0) begin
                prog_we    = 1'b1;
                prog_addr  = 4'd1;
                prog_wdata = 3'd7;
            end
            if (out_valid && out_ready) got_q.push_back(out_data);
            tick();
            prog_we = 1'b0;
            cyc++;
        end
        if (cyc >= 500) begin
            n_total++;
            $display("FAIL %s timeout: still busy after %0d cycles, required idle", name, cyc);
        end
    endtask

    task automatic chk_stream(input string name, input logic [7:0] nout, input logic [39:0] eout);
        logic [39:0] e;
        e = eout;
        chk({name, " count"}, 64'(got_q.size()), 64'(nout));
        for (int k = 0; k < int'(nout) && k < got_q.size(); k++)
            chk($sformatf("%s out%0d", name, k), 64'(got_q[k]), 64'(e[36-4*k +: 3]));
    endtask

    initial begin
        int cnt;
        logic [47:0] ones;
        ones = '1;

        vecs[0] = '{64'h0154_3000_0000_0000, 5'd6, 48'd729, 48'd0, 48'd0,
                    48'd0, 48'd0, 48'd0, 8'd10, 40'h4635_6352_10};
        vecs[1] = '{64'h2600_0000_0000_0000, 5'd2, 48'd0, 48'd0, 48'd9,
                    48'd0, 48'd1, 48'd9, 8'd0, 40'h0};
        vecs[2] = '{64'h1700_0000_0000_0000, 5'd2, 48'd0, 48'd29, 48'd0,
                    48'd0, 48'd26, 48'd0, 8'd0, 40'h0};
        vecs[3] = '{64'h4000_0000_0000_0000, 5'd2, 48'd0, 48'd2024, 48'd43690,
                    48'd0, 48'd44354, 48'd43690, 8'd0, 40'h0};
        vecs[4] = '{64'h5051_5400_0000_0000, 5'd6, 48'd10, 48'd0, 48'd0,
                    48'd10, 48'd0, 48'd0, 8'd3, 40'h0120_0000_00};
        vecs[5] = '{64'h0500_0000_0000_0000, 5'd2, ones, 48'd48, 48'd0,
                    48'd0, 48'd48, 48'd0, 8'd0, 40'h0};
        vecs[6] = '{64'h0500_0000_0000_0000, 5'd2, ones, 48'd47, 48'd0,
                    48'd1, 48'd47, 48'd0, 8'd0, 40'h0};
        vecs[7] = '{64'h6273_0000_0000_0000, 5'd4, 48'd100, 48'd0, 48'd0,
                    48'd100, 48'd25, 48'd12, 8'd0, 40'h0};
        vecs[8] = '{64'h3305_4000_0000_0000, 5'd5, 48'd5, 48'd0, 48'd0,
                    48'd5, 48'd0, 48'd0, 8'd1, 40'h5000_0000_00};
        vecs[9] = '{64'h5707_0000_0000_0000, 5'd4, 48'd3, 48'd3, 48'd0,
                    48'd3, 48'd3, 48'd0, 8'd1, 40'h0000_0000_00};

        rstn = 1'b0; prog_we = 1'b0; start = 1'b0; out_ready = 1'b1;
        prog_addr = '0; prog_wdata = '0; prog_len = '0;
        init_a = '0; init_b = '0; init_c = '0;
        tick(); tick();
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst halted", 64'(halted), 64'd0);
        chk("rst aborted", 64'(aborted), 64'd0);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_data", 64'(out_data), 64'd0);
        chk("rst reg_a", 64'(reg_a), 64'd0);
        rstn = 1'b1;
        tick();

        for (int v = 0; v < NV; v++) begin
            load_prog(vecs[v].prog);
            kick(vecs[v].len, vecs[v].ia, vecs[v].ib, vecs[v].ic);
            collect(1'b0, $sformatf("v%0d", v));
            chk($sformatf("v%0d halted", v), 64'(halted), 64'd1);
            chk($sformatf("v%0d aborted", v), 64'(aborted), 64'd0);
            chk($sformatf("v%0d reg_a", v), 64'(reg_a), 64'(vecs[v].ea));
            chk($sformatf("v%0d reg_b", v), 64'(reg_b), 64'(vecs[v].eb));
            chk($sformatf("v%0d reg_c", v), 64'(reg_c), 64'(vecs[v].ec));
            chk_stream($sformatf("v%0d", v), vecs[v].nout, vecs[v].eout);
        end

        // Backpressure: four outs fill the FIFO, the fifth stalls the machine.
        out_ready = 1'b0;
        load_prog(64'h5050_5050_5000_0000);
        kick(5'd10, 48'd10, 48'd0, 48'd0);
        for (int i = 0; i < 20; i++) tick();
        chk("bp busy held", 64'(busy), 64'd1);
        chk("bp out_valid", 64'(out_valid), 64'd1);
        chk("bp halted", 64'(halted), 64'd0);
        out_ready = 1'b1;
        collect(1'b0, "bp");
        chk_stream("bp", 8'd5, 40'h0000_0000_00);
        chk("bp halted end", 64'(halted), 64'd1);

        // Asynchronous reset in the middle of a stalled run.
        out_ready = 1'b0;
        kick(5'd10, 48'd10, 48'd7, 48'd7);
        for (int i = 0; i < 10; i++) tick();
        chk("mr pre out_valid", 64'(out_valid), 64'd1);
        rstn = 1'b0;
        #1;
        chk("mr busy", 64'(busy), 64'd0);
        chk("mr out_valid", 64'(out_valid), 64'd0);
        chk("mr out_data", 64'(out_data), 64'd0);
        chk("mr halted", 64'(halted), 64'd0);
        chk("mr reg_b", 64'(reg_b), 64'd0);
        tick();
        rstn = 1'b1;
        out_ready = 1'b1;
        tick();

        // Program writes during a run must be dropped.
        load_prog(vecs[4].prog);
        kick(5'd6, 48'd10, 48'd0, 48'd0);
        collect(1'b1, "we1");
        chk_stream("we1", 8'd3, 40'h0120_0000_00);
        kick(5'd6, 48'd10, 48'd0, 48'd0);
        collect(1'b0, "we2");
        chk_stream("we2", 8'd3, 40'h0120_0000_00);

        // Step limit on the MAX_STEPS=10 instance: jnz self-loop aborts after 10 instructions.
        load_prog(64'h3000_0000_0000_0000);
        kick(5'd2, 48'd1, 48'd0, 48'd0);
        cnt = 0;
        while (busy_s && cnt < 100) begin
            cnt++;
            tick();
        end
        chk("sl run cycles", 64'(cnt), 64'd10);
        chk("sl aborted", 64'(aborted_s), 64'd1);
        chk("sl busy", 64'(busy_s), 64'd0);
        chk("sl halted", 64'(halted_s), 64'd0);
        chk("sl reg_a", 64'(reg_a_s), 64'd1);
        kick(5'd2, 48'd0, 48'd0, 48'd0);
        cnt = 0;
        while (busy_s && cnt < 100) begin
            cnt++;
            tick();
        end
        chk("sl restart aborted", 64'(aborted_s), 64'd0);
        chk("sl restart halted", 64'(halted_s), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/opcode_core.md
Name: opcode_core

Overview:
Parametrised successor to the fixed 48-bit execute stage. It is a self-contained 3-bit-opcode machine:
- program store, fetch, decode and execute of the eight opcodes;
- A/B/C registers of configurable width;
- buffered program-output stream with valid/ready backpressure;
- step-limit watchdog.
It sits between the host load interface and the top-level output serializer.

Parameters:
REG_W, 48, width of registers A, B, C (>=8)
PROG_DEPTH, 16, program store entries (3-bit words), power of two
OUT_DEPTH, 4, output FIFO entries, power of two >=2
MAX_STEPS, 65535, executed-instruction limit per run before abort

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
prog_we  in  1  write program word (accepted only when not busy)
prog_addr  in  clog2(PROG_DEPTH)  program write address
prog_wdata  in  3  program word
prog_len  in  clog2(PROG_DEPTH)+1  number of valid program words, sampled at start
init_a / init_b / init_c  in  REG_W  initial register values, sampled at start
start  in  1  begin run (ignored while busy)
busy  out  1  high in RUN
halted  out  1  high after normal halt until next start
aborted  out  1  high after step-limit abort until next start
out_data  out  3  FIFO head value
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head when out_valid && out_ready
reg_a / reg_b / reg_c  out  REG_W  architectural registers (debug/result)

Behaviour:
- Reset: FSM=IDLE, ip=0, A=B=C=0, step count 0, FIFO empty. busy=0, halted=0, aborted=0, out_valid=0, out_data=0. Program store is not reset.
- FSM states: IDLE, RUN, HALT, ABORT.
  - IDLE/HALT/ABORT + start: load A/B/C from init_*, latch prog_len, ip=0, steps=0, flush FIFO, clear halted/aborted, go to RUN.
  - RUN: one instruction per cycle, unless stalled.
  - Fetch: opcode=mem[ip], operand=mem[ip+1], combinational.
- Halt check, done before executing: if ip+1 >= prog_len → HALT, halted=1 next cycle, no instruction executed.
- Literal operand: zero-extended operand.
- Combo operand: 0-3 literal; 4=A; 5=B; 6=C; 7=0 (reserved, no error).
- Shift amount: if combo >= REG_W, the shift result is 0. Shifter compares the full combo value, not truncated bits.
- Opcodes (results written at clock edge, one-cycle latency):
  - 0 adv: A=A>>combo
  - 1 bxl: B=B^lit
  - 2 bst: B=combo[2:0]
  - 3 jnz: A!=0 → ip=lit, else ip+=2 (odd targets legal)
  - 4 bxc: B=B^C (operand ignored)
  - 5 out: push combo[2:0]
  - 6 bdv: B=A>>combo
  - 7 cdv: C=A>>combo
  - All except jnz: ip+=2.
- ip arithmetic: done in clog2(PROG_DEPTH)+1 bits, so overflow past the store is caught by the halt check.
- Stall: an out opcode while FIFO is full (after same-cycle pop is considered) holds ip, registers and step count. Push-when-pop-same-cycle on a full FIFO proceeds.
- Step limit: steps increments per executed instruction. Executing with steps==MAX_STEPS-1 completes that instruction, then the FSM goes to ABORT with aborted=1.
- FIFO:
  - Pop continues in every state.
  - Simultaneous push+pop keeps the count.
  - Pointers wrap modulo OUT_DEPTH.
  - out_data is valid only when out_valid.
  - Flush on start takes priority over a same-cycle pop.
- prog_we while busy is ignored. start while busy is ignored.
- rstn asserted mid-run: immediate return to reset values; FIFO contents are lost.

Decomposition:
- Shared package opcode_pkg:
  - opcode localparams OP_ADV..OP_CDV;
  - combo-select encodings;
  - FSM state encodings ST_IDLE/ST_RUN/ST_HALT/ST_ABORT;
  - width helper for ip (clog2(PROG_DEPTH)+1).
- One sub-module: out_fifo (parametrised WIDTH=3, DEPTH=OUT_DEPTH; push/pop/flush, full/empty). Core decode/ALU stays in opcode_core.

Test Plan:
- Reference run: A=729, B=0, C=0, prog 0,1,5,4,3,0, out_ready=1 → stream 4,6,3,5,6,3,5,2,1,0; halted=1, A=0.
- Single ops:
  - C=9, prog 2,6 → B=1.
  - B=29, prog 1,7 → B=26.
  - B=2024, C=43690, prog 4,0 → B=44354.
  - A=10, prog 5,0,5,1,5,4 → outputs 0,1,2.
- Backpressure: OUT_DEPTH=4, out_ready=0, A=10, prog 5,0,5,0,5,0,5,0,5,0 → 4 entries buffered, busy held, ip frozen at 8. Raise out_ready → 5 zeros total, then halted.
- Shift bound: REG_W=48, A=all-ones, B=48, prog 0,5 → A=0. With B=47 → A=1.
- Step limit: MAX_STEPS=10, A=1, prog 3,0 (infinite loop) → aborted=1 after 10 instructions, busy=0. A later start clears aborted.
- Reset/restart: assert rstn low mid-run with a non-empty FIFO → all outputs 0 immediately. prog_we during RUN does not alter the program (rerun gives identical output).
